// File: rtl/flght_pkg.sv
// Shared types and constants for the flight command sequencer.
//   opcode_e : command opcodes accepted from the UART receiver
//   state_e  : sequencer states
//   POS_ACK / NEG_ACK : response bytes for valid / unknown opcodes
package flght_pkg;

    typedef enum logic [7:0] {
        REQ_BATT  = 8'h01,
        SET_PTCH  = 8'h02,
        SET_ROLL  = 8'h03,
        SET_YAW   = 8'h04,
        SET_THRST = 8'h05,
        CALIBRATE = 8'h06,
        EMER_LAND = 8'h07,
        MTRS_OFF  = 8'h08
    } opcode_e;

    localparam logic [7:0] POS_ACK = 8'hA5;
    localparam logic [7:0] NEG_ACK = 8'hEE;

    typedef enum logic [1:0] {
        StIdle,
        StEscWait,
        StCal,
        StResp
    } state_e;

endpackage

// File: rtl/flght_tmr.sv
// Loadable up-counter with terminal flag. Counts while en is high and
// saturates at all-ones; clr returns it to zero.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : load zero (wins over en)
//   en         : count enable
//   done       : counter is all-ones
module flght_tmr #(
    parameter int unsigned W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic done
);

    logic [W-1:0] cnt_q;

    assign done = &cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !done) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/flght_cmd_ctrl.sv
// Command sequencer between the UART command receiver and the flight
// controller. Decodes opcode/data pairs into setpoint updates, runs the
// ESC wake-up then inertial calibration sequence, controls motor enable and
// returns one response byte per command.
// Optional feature: define CMD_WDOG_EN to add a command watchdog that forces
// an emergency landing when no command arrives for 2^WDOG_W clocks while
// thrust is nonzero.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   cmd_rdy, cmd, data    : incoming command; clr_cmd_rdy consumes it
//   batt                  : battery reading returned by REQ_BATT
//   cal_done / strt_cal   : inertial calibration handshake
//   inertial_cal          : high during ESC wait and calibration
//   resp, send_resp       : response byte and its start strobe
//   resp_sent             : UART finished sending resp
//   d_ptch, d_roll, d_yaw : signed attitude setpoints
//   thrst                 : unsigned thrust setpoint
//   motors_off            : forces the ESCs to idle
module flght_cmd_ctrl
    import flght_pkg::*;
#(
    parameter int unsigned ESC_WAIT_W = 26,
    parameter int unsigned WDOG_W     = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_rdy,
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    input  logic [7:0]  batt,
    input  logic        cal_done,
    input  logic        resp_sent,
    output logic        clr_cmd_rdy,
    output logic [7:0]  resp,
    output logic        send_resp,
    output logic [15:0] d_ptch,
    output logic [15:0] d_roll,
    output logic [15:0] d_yaw,
    output logic [8:0]  thrst,
    output logic        strt_cal,
    output logic        inertial_cal,
    output logic        motors_off
);

    state_e state_q, state_d;

    logic        clr_q, clr_d;
    logic        send_q, send_d;
    logic        strt_q, strt_d;
    logic        inertial_q, inertial_d;
    logic        moff_q, moff_d;
    logic [7:0]  resp_q, resp_d;
    logic [15:0] ptch_q, ptch_d;
    logic [15:0] roll_q, roll_d;
    logic [15:0] yaw_q, yaw_d;
    logic [8:0]  thrst_q, thrst_d;

    logic accept;
    logic esc_done;

    assign accept = (state_q == StIdle) && cmd_rdy;

    flght_tmr #(
        .W(ESC_WAIT_W)
    ) u_esc_tmr (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (accept),
        .en   (state_q == StEscWait),
        .done (esc_done)
    );

`ifdef CMD_WDOG_EN
    logic wdog_done;
    logic wdog_fire;

    // Frozen while calibrating; the sequence itself proves the link is alive.
    flght_tmr #(
        .W(WDOG_W)
    ) u_wdog_tmr (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (accept),
        .en   ((state_q == StIdle) || (state_q == StResp)),
        .done (wdog_done)
    );

    assign wdog_fire = wdog_done && (thrst_q != '0) && !accept;
`else
    logic unused_wdog_w;
    assign unused_wdog_w = (WDOG_W == 0);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_rdy) begin
                    state_d = (cmd == CALIBRATE) ? StEscWait : StResp;
                end
            end
            StEscWait: if (esc_done)  state_d = StCal;
            StCal:     if (cal_done)  state_d = StResp;
            StResp:    if (resp_sent) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Output logic: next values of the registered outputs and setpoints
    always_comb begin
        clr_d      = 1'b0;
        send_d     = 1'b0;
        strt_d     = 1'b0;
        inertial_d = inertial_q;
        moff_d     = moff_q;
        resp_d     = resp_q;
        ptch_d     = ptch_q;
        roll_d     = roll_q;
        yaw_d      = yaw_q;
        thrst_d    = thrst_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_rdy) begin
                    clr_d  = 1'b1;
                    resp_d = POS_ACK;
                    case (cmd)
                        REQ_BATT:  resp_d = batt;
                        SET_PTCH:  ptch_d = data;
                        SET_ROLL:  roll_d = data;
                        SET_YAW:   yaw_d  = data;
                        SET_THRST: begin
                            thrst_d = data[8:0];
                            moff_d  = 1'b0;
                        end
                        CALIBRATE: moff_d = 1'b0;
                        EMER_LAND: begin
                            ptch_d  = '0;
                            roll_d  = '0;
                            yaw_d   = '0;
                            thrst_d = '0;
                        end
                        MTRS_OFF:  moff_d = 1'b1;
                        default:   resp_d = NEG_ACK;
                    endcase
                    // Calibrate answers only after cal_done
                    if (cmd == CALIBRATE) begin
                        inertial_d = 1'b1;
                    end else begin
                        send_d = 1'b1;
                    end
                end
            end
            StEscWait: begin
                if (esc_done) strt_d = 1'b1;
            end
            StCal: begin
                if (cal_done) begin
                    inertial_d = 1'b0;
                    resp_d     = POS_ACK;
                    send_d     = 1'b1;
                end
            end
            StResp: begin
            end
            default: begin
            end
        endcase

`ifdef CMD_WDOG_EN
        if (wdog_fire) begin
            ptch_d  = '0;
            roll_d  = '0;
            yaw_d   = '0;
            thrst_d = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_q      <= 1'b0;
            send_q     <= 1'b0;
            strt_q     <= 1'b0;
            inertial_q <= 1'b0;
            moff_q     <= 1'b1;
            resp_q     <= '0;
            ptch_q     <= '0;
            roll_q     <= '0;
            yaw_q      <= '0;
            thrst_q    <= '0;
        end else begin
            clr_q      <= clr_d;
            send_q     <= send_d;
            strt_q     <= strt_d;
            inertial_q <= inertial_d;
            moff_q     <= moff_d;
            resp_q     <= resp_d;
            ptch_q     <= ptch_d;
            roll_q     <= roll_d;
            yaw_q      <= yaw_d;
            thrst_q    <= thrst_d;
        end
    end

    assign clr_cmd_rdy  = clr_q;
    assign send_resp    = send_q;
    assign strt_cal     = strt_q;
    assign inertial_cal = inertial_q;
    assign motors_off   = moff_q;
    assign resp         = resp_q;
    assign d_ptch       = ptch_q;
    assign d_roll       = roll_q;
    assign d_yaw        = yaw_q;
    assign thrst        = thrst_q;

endmodule

// File: tb/tb_flght_cmd_ctrl.sv
// Self-checking bench for flght_cmd_ctrl: table of single commands, then
// hand-written calibrate, reset-abort and watchdog sequences. Expected
// response bytes go into a scoreboard queue when a command is driven and are
// popped whenever the DUT strobes send_resp.
module tb_flght_cmd_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic [7:0]  batt;
    logic        cal_done;
    logic        resp_sent;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic [15:0] d_ptch;
    logic [15:0] d_roll;
    logic [15:0] d_yaw;
    logic [8:0]  thrst;
    logic        strt_cal;
    logic        inertial_cal;
    logic        motors_off;

    int errs   = 0;
    int checks = 0;
    int n_send = 0;
    int n_done = 0;
    logic [7:0] sb[$];

    flght_cmd_ctrl #(
        .ESC_WAIT_W(9),
        .WDOG_W    (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_rdy     (cmd_rdy),
        .cmd         (cmd),
        .data        (data),
        .batt        (batt),
        .cal_done    (cal_done),
        .resp_sent   (resp_sent),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .d_ptch      (d_ptch),
        .d_roll      (d_roll),
        .d_yaw       (d_yaw),
        .thrst       (thrst),
        .strt_cal    (strt_cal),
        .inertial_cal(inertial_cal),
        .motors_off  (motors_off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard check plus UART model: answers resp_sent a few cycles later.
    initial begin
        logic [7:0] e;
        resp_sent = 1'b0;
        forever begin
            @(negedge clk);
            if (send_resp) begin
                n_send++;
                if (sb.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_resp: got %0h expected none", resp);
                    e = resp;
                end else begin
                    e = sb.pop_front();
                    check("resp", 32'(resp), 32'(e));
                end
                repeat (3) @(negedge clk);
                check("resp_held", 32'(resp), 32'(e));
                resp_sent = 1'b1;
                @(negedge clk);
                resp_sent = 1'b0;
                n_done++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    // Wait for clr_cmd_rdy; returns cycles waited (limit if never seen).
    task automatic wait_clr(input int limit, output int k);
        k = 0;
        while (k < limit) begin
            @(negedge clk);
            k++;
            if (clr_cmd_rdy) break;
        end
    endtask

    task automatic wait_done(input int target);
        int k;
        k = 0;
        while (n_done < target && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("resp_done_timeout", 32'(n_done >= target), 32'd1);
        @(negedge clk);
    endtask

    task automatic do_cmd(input logic [7:0] op, input logic [15:0] dat, input logic [7:0] r);
        int k;
        int tgt;
        tgt = n_done + 1;
        @(negedge clk);
        cmd     = op;
        data    = dat;
        cmd_rdy = 1'b1;
        sb.push_back(r);
        wait_clr(50, k);
        check("clr_latency", 32'(k), 32'd1);
        check("send_with_clr", 32'(send_resp), 32'd1);
        cmd_rdy = 1'b0;
        wait_done(tgt);
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [15:0] dat;
        logic [7:0]  bat;
        logic [7:0]  r;
        logic [15:0] p;
        logic [15:0] ro;
        logic [15:0] y;
        logic [8:0]  t;
        logic        mo;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int k;
        int tgt;
        int clr_seen;
        int strt_t;
        int strt_cnt;
        int ns;

        vecs[0] = '{8'h05, 16'h01FF, 8'h00, 8'hA5, 16'h0000, 16'h0000, 16'h0000, 9'h1FF, 1'b0};
        vecs[1] = '{8'h02, 16'hFFF0, 8'h00, 8'hA5, 16'hFFF0, 16'h0000, 16'h0000, 9'h1FF, 1'b0};
        vecs[2] = '{8'h03, 16'h0010, 8'h00, 8'hA5, 16'hFFF0, 16'h0010, 16'h0000, 9'h1FF, 1'b0};
        vecs[3] = '{8'h04, 16'h8000, 8'h00, 8'hA5, 16'hFFF0, 16'h0010, 16'h8000, 9'h1FF, 1'b0};
        vecs[4] = '{8'h01, 16'h1234, 8'hC3, 8'hC3, 16'hFFF0, 16'h0010, 16'h8000, 9'h1FF, 1'b0};
        vecs[5] = '{8'h2A, 16'h5555, 8'h00, 8'hEE, 16'hFFF0, 16'h0010, 16'h8000, 9'h1FF, 1'b0};
        vecs[6] = '{8'h07, 16'hFFFF, 8'h00, 8'hA5, 16'h0000, 16'h0000, 16'h0000, 9'h000, 1'b0};
        vecs[7] = '{8'h08, 16'h0000, 8'h00, 8'hA5, 16'h0000, 16'h0000, 16'h0000, 9'h000, 1'b1};
        vecs[8] = '{8'h05, 16'h7E64, 8'h00, 8'hA5, 16'h0000, 16'h0000, 16'h0000, 9'h064, 1'b0};
        vecs[9] = '{8'h08, 16'h0000, 8'h00, 8'hA5, 16'h0000, 16'h0000, 16'h0000, 9'h064, 1'b1};

        rst_n    = 1'b0;
        cmd_rdy  = 1'b0;
        cmd      = '0;
        data     = '0;
        batt     = '0;
        cal_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ptch", 32'(d_ptch), 32'd0);
        check("rst_thrst", 32'(thrst), 32'd0);
        check("rst_motors_off", 32'(motors_off), 32'd1);
        check("rst_resp", 32'(resp), 32'd0);
        check("rst_strobes", 32'({clr_cmd_rdy, send_resp, strt_cal, inertial_cal}), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            batt = vecs[i].bat;
            do_cmd(vecs[i].op, vecs[i].dat, vecs[i].r);
            check($sformatf("v%0d_ptch", i), 32'(d_ptch), 32'(vecs[i].p));
            check($sformatf("v%0d_roll", i), 32'(d_roll), 32'(vecs[i].ro));
            check($sformatf("v%0d_yaw", i), 32'(d_yaw), 32'(vecs[i].y));
            check($sformatf("v%0d_thrst", i), 32'(thrst), 32'(vecs[i].t));
            check($sformatf("v%0d_motors_off", i), 32'(motors_off), 32'(vecs[i].mo));
        end

        // Calibrate: 512-cycle ESC wait, pending command held off, stray cal_done ignored.
        tgt = n_done + 2;
        @(negedge clk);
        cmd     = 8'h06;
        data    = 16'h0000;
        cmd_rdy = 1'b1;
        sb.push_back(8'hA5);
        @(negedge clk);
        check("cal_clr", 32'(clr_cmd_rdy), 32'd1);
        check("cal_inertial_on", 32'(inertial_cal), 32'd1);
        check("cal_motors_on", 32'(motors_off), 32'd0);
        check("cal_no_early_send", 32'(send_resp), 32'd0);
        cmd_rdy  = 1'b0;
        clr_seen = 0;
        strt_t   = -1;
        for (int i = 1; i <= 2000 && strt_t < 0; i++) begin
            if (i == 100) begin
                cmd     = 8'h02;
                data    = 16'h1234;
                cmd_rdy = 1'b1;
                sb.push_back(8'hA5);
            end
            if (i == 200) cal_done = 1'b1;
            if (i == 201) cal_done = 1'b0;
            @(negedge clk);
            if (clr_cmd_rdy) clr_seen++;
            if (strt_cal) strt_t = i;
        end
        check("strt_cal_delay", 32'(strt_t), 32'd512);
        check("esc_wait_no_consume", 32'(clr_seen), 32'd0);
        check("inertial_at_strt", 32'(inertial_cal), 32'd1);
        ns = n_send;
        repeat (5) @(negedge clk);
        check("strt_cal_pulse", 32'(strt_cal), 32'd0);
        check("cal_wait_no_send", 32'(n_send), 32'(ns));
        cal_done = 1'b1;
        @(negedge clk);
        cal_done = 1'b0;
        check("cal_send", 32'(send_resp), 32'd1);
        check("cal_inertial_off", 32'(inertial_cal), 32'd0);
        wait_clr(100, k);
        check("pending_consumed", 32'(k < 100), 32'd1);
        cmd_rdy = 1'b0;
        wait_done(tgt);
        check("pending_ptch", 32'(d_ptch), 32'h1234);
        check("cal_thrst_kept", 32'(thrst), 32'h064);

        // Reset during ESC wait aborts without a response.
        @(negedge clk);
        cmd     = 8'h06;
        cmd_rdy = 1'b1;
        wait_clr(50, k);
        check("abort_clr", 32'(k), 32'd1);
        cmd_rdy = 1'b0;
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_inertial", 32'(inertial_cal), 32'd0);
        check("abort_motors_off", 32'(motors_off), 32'd1);
        check("abort_thrst", 32'(thrst), 32'd0);
        check("abort_ptch", 32'(d_ptch), 32'd0);
        check("abort_resp", 32'(resp), 32'd0);
        rst_n    = 1'b1;
        ns       = n_send;
        strt_cnt = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (strt_cal) strt_cnt++;
        end
        check("abort_no_strt", 32'(strt_cnt), 32'd0);
        check("abort_no_send", 32'(n_send), 32'(ns));

        // Thrust with no further commands: watchdog lands only when built in.
        do_cmd(8'h05, 16'h0064, 8'hA5);
        repeat (190) @(negedge clk);
        check("wdog_before", 32'(thrst), 32'h064);
        repeat (100) @(negedge clk);
`ifdef CMD_WDOG_EN
        check("wdog_landed", 32'(thrst), 32'd0);
`else
        check("no_wdog_thrst", 32'(thrst), 32'h064);
`endif

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/flght_cmd_ctrl.md
# flght_cmd_ctrl

Command sequencer between the UART command receiver and the flight controller. Decodes each received 8-bit opcode and 16-bit data word, and updates the flight setpoints (pitch, roll, yaw, thrust). Sequences the ESC-wakeup-then-inertial-calibration procedure and controls motor enable. Returns exactly one response byte per command to the wireless link.

## Interface
- ESC_WAIT_W, 26: width of the ESC wake-up timer; the wait lasts 2^ESC_WAIT_W clocks.
- WDOG_W, 26: width of the command watchdog counter; only used with CMD_WDOG_EN.
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  reset, synchronous and active-low; sampled only on posedge clk.
- cmd_rdy  in  1  level; a new command/data pair is valid.
- cmd  in  8  opcode.
- data  in  16  command data.
- batt  in  8  latest battery voltage reading (upper A2D bits).
- cal_done  in  1  pulse from the inertial interface; calibration finished.
- resp_sent  in  1  pulse; the UART transmitter finished sending the response byte.
- clr_cmd_rdy  out  1  one-cycle pulse; consumes the current command.
- resp  out  8  response byte; held stable from send_resp until resp_sent.
- send_resp  out  1  one-cycle pulse; starts transmission of resp.
- d_ptch, d_roll, d_yaw  out  16  signed setpoints.
- thrst  out  9  unsigned thrust setpoint.
- strt_cal  out  1  one-cycle pulse; starts inertial calibration.
- inertial_cal  out  1  high from ESC wait start until cal_done.
- motors_off  out  1  forces the ESCs to idle.

## Operation
- Opcodes:
  - 01 REQ_BATT: resp=batt.
  - 02 SET_PTCH: d_ptch=data.
  - 03 SET_ROLL: d_roll=data.
  - 04 SET_YAW: d_yaw=data.
  - 05 SET_THRST: thrst=data[8:0], data[15:9] ignored; clears motors_off.
  - 06 CALIBRATE: clears motors_off, then runs the calibration sequence.
  - 07 EMER_LAND: d_ptch, d_roll, d_yaw and thrst all set to 0.
  - 08 MTRS_OFF: sets motors_off.
  - Any other opcode: no setpoint change; resp=8'hEE (negative ack).
- Acknowledge: every valid opcode except 01 answers with resp=8'hA5.
- States:
  - IDLE: when cmd_rdy=1, pulse clr_cmd_rdy, apply the register update and load resp. Go to RESP, except opcode 06, which goes to ESC_WAIT.
  - ESC_WAIT: inertial_cal=1; the timer counts from 0 to all-ones, then pulse strt_cal and go to CAL.
  - CAL: wait for cal_done, then drop inertial_cal, load resp=A5 and go to RESP.
  - RESP: send_resp pulses on the first cycle only. Then wait for resp_sent and go to IDLE.
- cmd_rdy is ignored outside IDLE; the command remains pending upstream and is serviced on return to IDLE.
- A cal_done pulse outside CAL is ignored.
- Setpoints are plain registers with no saturation; signed values pass through unchanged (16'h8000 is legal).

## Timing
- Reset values: d_ptch=d_roll=d_yaw=0, thrst=0, motors_off=1, resp=0, and all pulses/strobes (clr_cmd_rdy, send_resp, strt_cal) and inertial_cal low; state IDLE; timers 0.
- Latency, non-calibrate command:
  - Edge N samples cmd_rdy=1 in IDLE.
  - Cycle N+1: clr_cmd_rdy=1, setpoints and resp updated, send_resp=1 (same cycle).
  - Earliest next command sample: edge following resp_sent.
- Latency, calibrate:
  - inertial_cal and ESC wait start at N+1.
  - strt_cal pulses at N+1+2^ESC_WAIT_W.
  - send_resp pulses 1 cycle after cal_done is sampled.
- rst_n low at any edge, including mid-calibration or mid-response, returns every output to its reset value on that edge; no response is sent for the aborted command.
- resp_sent arriving the same cycle as send_resp is not possible (the UART needs >1 cycle); it is sampled only in RESP.

## Configuration
- CMD_WDOG_EN defined: a WDOG_W-bit counter clears on every accepted command.
  - On reaching all-ones while thrst≠0, it performs the EMER_LAND register update internally. No response is sent.
  - The counter then holds until the next command. It is frozen during ESC_WAIT and CAL.
- CMD_WDOG_EN undefined: no watchdog logic; setpoints change only via commands or reset.

## Structure
- Shared package flght_pkg:
  - opcode enum (REQ_BATT..MTRS_OFF).
  - POS_ACK=8'hA5, NEG_ACK=8'hEE.
  - state enum.
- One sub-module: flght_tmr, a loadable up-counter with a terminal flag, instanced for the ESC wait and (under CMD_WDOG_EN) the watchdog.

## Test plan
- Reset, then SET_THRST data=16'h01FF:
  - thrst=9'h1FF, motors_off 1→0.
  - one clr_cmd_rdy, one send_resp with resp=A5.
- SET_PTCH 16'hFFF0, SET_ROLL 16'h0010, SET_YAW 16'h8000: registers match exactly; three A5 responses.
- REQ_BATT with batt=8'hC3 → resp=C3, no setpoint change. Opcode 8'h2A → resp=EE.
- EMER_LAND after nonzero setpoints → all four setpoints 0, A5. Then MTRS_OFF → motors_off=1, A5.
- CALIBRATE with ESC_WAIT_W=9:
  - strt_cal exactly 512 cycles after clr_cmd_rdy.
  - cmd_rdy raised during the wait is not consumed.
  - cal_done → A5, then the pending command is consumed.
- rst_n low during ESC_WAIT → inertial_cal=0, motors_off=1, no send_resp. With CMD_WDOG_EN and WDOG_W=8, thrst=100 and no commands → thrst=0 after 256 cycles.
